// File: rtl/mux2_arb.sv
// ---------------------------------------------------------------------------
// mux2_arb -- two-channel valid/ready arbiter feeding a one-entry output
// register. Contention is resolved round robin against the last granted
// channel; channel 0 wins the first contention after reset.
//
// Parameters:
//   W           data width of every channel
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in0_*       channel 0 valid/ready/data
//   in1_*       channel 1 valid/ready/data
//   out_valid   output register holds a word
//   out_ready   downstream takes the word this cycle
//   out_data    registered payload
//   out_sel     channel the registered payload came from
//   gnt_cnt0/1  saturating per-channel load counters, only present when
//               the macro MUX2_ARB_GNT_CNT_EN is defined
// ---------------------------------------------------------------------------
module mux2_arb #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in0_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [W-1:0] in1_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sel
`ifdef MUX2_ARB_GNT_CNT_EN
    ,
    output logic [7:0]   gnt_cnt0,
    output logic [7:0]   gnt_cnt1
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_sel_q, out_sel_d;
    logic           last_gnt_q, last_gnt_d;
    logic           load;
    logic           gnt;

    // Load whenever the register is (or is about to become) free and
    // something is offered. On contention the channel other than the last
    // winner is granted; otherwise whichever channel is valid.
    always_comb begin
        load = ((state_q == S_EMPTY) || out_ready) && (in0_valid || in1_valid);
        gnt  = (in0_valid && in1_valid) ? ~last_gnt_q : in1_valid;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (load)                state_d = S_FULL;
            S_FULL:  if (out_ready && !load) state_d = S_EMPTY;
            default:                          state_d = S_EMPTY;
        endcase
    end

    // Output logic. Readies are gated by rst_n so nothing is accepted while
    // reset is held, even though the registers already read EMPTY.
    always_comb begin
        out_valid = (state_q == S_FULL);
        in0_ready = rst_n && load && !gnt;
        in1_ready = rst_n && load && gnt;
    end

    // Datapath: payload, select and round-robin pointer change only on load
    always_comb begin
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        last_gnt_d = last_gnt_q;
        if (load) begin
            out_data_d = gnt ? in1_data : in0_data;
            out_sel_d  = gnt;
            last_gnt_d = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_sel_q  <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign out_data = out_data_q;
    assign out_sel  = out_sel_q;

`ifdef MUX2_ARB_GNT_CNT_EN
    logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

    // Per-channel load counters, saturating at all-ones
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (load && !gnt && (gnt_cnt0_q != 8'hFF)) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
        if (load && gnt  && (gnt_cnt1_q != 8'hFF)) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= 8'd0;
            gnt_cnt1_q <= 8'd0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_mux2_arb.sv
// ---------------------------------------------------------------------------
// tb_mux2_arb -- self-checking bench for mux2_arb (W=8).
// A directed vector table, a mid-FULL reset sequence, a randomized run
// against a transaction-level model with a scoreboard queue and, when
// MUX2_ARB_GNT_CNT_EN is defined, a grant counter saturation sequence.
// ---------------------------------------------------------------------------
module tb_mux2_arb;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in0_valid, in0_ready;
    logic [W-1:0] in0_data;
    logic         in1_valid, in1_ready;
    logic [W-1:0] in1_data;
    logic         out_valid, out_ready;
    logic [W-1:0] out_data;
    logic         out_sel;
`ifdef MUX2_ARB_GNT_CNT_EN
    logic [7:0]   gnt_cnt0, gnt_cnt1;
`endif

    mux2_arb #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef MUX2_ARB_GNT_CNT_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: one optional held word plus the last winner.
    logic         m_full;
    logic [W-1:0] m_data;
    logic         m_sel;
    logic         m_last;
    logic [W:0]   sb[$];   // {sel, data} of words accepted but not yet taken

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_sel  = 1'b0;
        m_last = 1'b1;
        sb.delete();
    endtask

    // One clock: readies and scoreboard at the negedge, outputs #1 after posedge.
    task automatic step();
        logic         ld, g;
        logic [W-1:0] d;
        logic [W:0]   w;
        @(negedge clk);
        ld = (!m_full || out_ready) && (in0_valid || in1_valid);
        if (in0_valid && in1_valid) g = ~m_last;
        else                        g = in1_valid;
        d = g ? in1_data : in0_data;
        chk("in0_ready", {31'd0, in0_ready}, {31'd0, ld && !g});
        chk("in1_ready", {31'd0, in1_ready}, {31'd0, ld && g});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra at %0t: got word %0h expected none", $time, {out_sel, out_data});
            end else begin
                w = sb.pop_front();
                chk("sb_word", {23'd0, out_sel, out_data}, {23'd0, w});
            end
        end
        if (ld) sb.push_back({g, d});
        @(posedge clk);
        if (ld) begin
            m_full = 1'b1;
            m_data = d;
            m_sel  = g;
            m_last = g;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
        chk("out_sel",   {31'd0, out_sel},   {31'd0, m_sel});
    endtask

    typedef struct {
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         ordy;
        logic         r0;
        logic         r1;
        logic         ov;
        logic [W-1:0] od;
        logic         os;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    initial begin
        // inputs: v0 d0 v1 d1 out_ready | expected: rdy0 rdy1 out_valid out_data out_sel
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        tbl[4]  = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[5]  = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[6]  = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[7]  = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[8]  = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h71, 1'b1, 1'b0, 1'b1, 1'b1, 8'h71, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h72, 1'b1, 1'b0, 1'b1, 1'b1, 8'h72, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h73, 1'b1, 1'b0, 1'b1, 1'b1, 8'h73, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h74, 1'b1, 1'b0, 1'b1, 1'b1, 8'h74, 1'b1};
        tbl[13] = '{1'b1, 8'h81, 1'b1, 8'h82, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 8'h90, 1'b0, 1'b0, 1'b1, 1'b1, 8'h90, 1'b1};

        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in0_data  = '0;
        in1_valid = 1'b0;
        in1_data  = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state, readies held low while in reset even with a valid input
        @(posedge clk);
        in0_valid = 1'b1;
        in0_data  = 8'hA5;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_sel",   {31'd0, out_sel},   32'd0);
        chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
        chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        @(posedge clk);
        #1;

        // Directed table; reset releases together with the first vector
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in0_valid = tbl[i].v0;
            in0_data  = tbl[i].d0;
            in1_valid = tbl[i].v1;
            in1_data  = tbl[i].d1;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk("vec_in0_ready", {31'd0, in0_ready}, {31'd0, tbl[i].r0});
            chk("vec_in1_ready", {31'd0, in1_ready}, {31'd0, tbl[i].r1});
            @(posedge clk);
            #1;
            chk("vec_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].ov});
            chk("vec_out_data",  {24'd0, out_data},  {24'd0, tbl[i].od});
            chk("vec_out_sel",   {31'd0, out_sel},   {31'd0, tbl[i].os});
            $display("vec %0d: v0=%0b v1=%0b ordy=%0b -> rdy=%0b%0b out_valid=%0b data=%02h sel=%0b",
                     i, tbl[i].v0, tbl[i].v1, tbl[i].ordy, in1_ready, in0_ready,
                     out_valid, out_data, out_sel);
        end

        // Reset while FULL discards the word immediately
        in0_valid = 1'b1;
        in0_data  = 8'hA5;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data",  {24'd0, out_data},  32'd0);
        chk("midrst_out_sel",   {31'd0, out_sel},   32'd0);
        chk("midrst_in0_ready", {31'd0, in0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
        $display("reset mid-FULL: out_valid=%0b out_data=%02h", out_valid, out_data);

        // Release: first edge after reset loads the offered word
        rst_n = 1'b1;
        model_reset();
        step();
        chk("post_rst_load", {24'd0, out_data}, 32'h0000_00A5);
        $display("post-reset load: out_valid=%0b data=%02h sel=%0b", out_valid, out_data, out_sel);

        // Randomized run against the model and scoreboard
        for (int c = 0; c < 10000; c++) begin
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            in0_data  = 8'($urandom);
            in1_data  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        // Drain and confirm every accepted word came out exactly once
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("random run: 10000 cycles, scoreboard residue %0d", sb.size());

`ifdef MUX2_ARB_GNT_CNT_EN
        // Saturating grant counters
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("cnt_rst0", {24'd0, gnt_cnt0}, 32'd0);
        chk("cnt_rst1", {24'd0, gnt_cnt1}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        in0_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            in0_data = 8'(c);
            step();
        end
        in0_valid = 1'b0;
        in1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in1_data = 8'(c);
            step();
        end
        chk("gnt_cnt0", {24'd0, gnt_cnt0}, 32'd255);
        chk("gnt_cnt1", {24'd0, gnt_cnt1}, 32'd5);
        $display("grant counters: cnt0=%0d cnt1=%0d", gnt_cnt0, gnt_cnt1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 Parameter: W, default 8, data width of every channel in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in0_valid  input  1  channel 0 offers data.
REQ-005 in0_ready  output  1  channel 0 data accepted this cycle.
REQ-006 in0_data  input  W  channel 0 payload.
REQ-007 in1_valid  input  1  channel 1 offers data.
REQ-008 in1_ready  output  1  channel 1 data accepted this cycle.
REQ-009 in1_data  input  W  channel 1 payload.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_ready  input  1  downstream takes the word this cycle.
REQ-012 out_data  output  W  registered payload.
REQ-013 out_sel  output  1  source channel of out_data (0 or 1), the registered mux select.

Function
REQ-014 The block SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load = (EMPTY or (FULL and out_ready)) and (in0_valid or in1_valid); the output register SHALL load only when load=1.
REQ-016 Transitions SHALL be: EMPTY->FULL on load; FULL->EMPTY on out_ready with no load; FULL->FULL on out_ready with load, or while out_ready=0.
REQ-017 Grant: only in0_valid set -> channel 0; only in1_valid set -> channel 1; both set -> the channel not equal to last_gnt (round robin).
REQ-018 last_gnt SHALL update to the granted channel on every load only.
REQ-019 inN_ready SHALL be 1 only for the granted channel when load=1, else 0; both readies SHALL never be 1 together.
REQ-020 in_ready SHALL be combinational from the in_valids, out_ready and state; no combinational path SHALL run from any input to out_valid, out_data or out_sel.
REQ-021 Latency SHALL be one cycle from accepted input to out_valid; throughput one word per cycle when out_ready is held 1.
REQ-022 While FULL and out_ready=0, out_data and out_sel SHALL hold stable and both in_readys SHALL be 0.
REQ-023 A word SHALL never be dropped or duplicated; an unaccepted input valid SHALL leave that channel's state unchanged.
REQ-024 When EMPTY, out_data and out_sel SHALL hold their last values (don't-care to downstream).

Reset
REQ-025 rst_n=0 SHALL immediately force state EMPTY, out_valid=0, out_data=0, out_sel=0, last_gnt=1 (channel 0 wins first contention).
REQ-026 Reset asserted while FULL SHALL discard the held word; readies SHALL be 0 while rst_n=0.
REQ-027 The first load SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro MUX2_ARB_GNT_CNT_EN: when defined, add outputs gnt_cnt0 and gnt_cnt1 (8 bits each), counting loads from channel 0 and 1 respectively, saturating at 255, reset to 0.
REQ-029 Without MUX2_ARB_GNT_CNT_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset with in0_valid=1, in0_data=8'hA5, out_ready=1 -> next edge out_valid=1, out_data=A5, out_sel=0; reset mid-FULL -> out_valid=0 immediately.
REQ-031 Both valid every cycle, data 8'h11/8'h22, out_ready=1 -> out_data alternates 11,22,11,22; out_sel 0,1,0,1; one word per cycle.
REQ-032 FULL with out_data=8'h33, out_ready=0 for 3 cycles -> out_data steady at 33, in0_ready=in1_ready=0; out_ready=1 -> next word loads the same cycle.
REQ-033 Only in1_valid=1 for 4 cycles, out_ready=1 -> four grants to channel 1, in0_ready=0 throughout; then both valid -> channel 0 granted.
REQ-034 With MUX2_ARB_GNT_CNT_EN, 300 channel-0 loads and 5 channel-1 loads -> gnt_cnt0=255, gnt_cnt1=5.
REQ-035 Random valids and out_ready for 10000 cycles -> scoreboard: output sequence equals accepted-input sequence, no loss, no duplication.
